// File: rtl/hack_boot_pkg.sv
// hack_boot_pkg: shared definitions for the Hack boot loader.
//   - boot_state_e : loader FSM state encoding
//   - HDR_*        : byte positions of the image header (big-endian word count)
//   - is_loading() : true in the states that hold the CPU in reset while bytes arrive
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds the CHK_HI/CHK_LO trailer states.
package hack_boot_pkg;

  typedef enum logic [3:0] {
    ST_ROM     = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
`ifdef BOOT_LOADER_CHECKSUM_EN
    ST_CHK_HI  = 4'd5,
    ST_CHK_LO  = 4'd6,
`endif
    ST_RUN     = 4'd7,
    ST_ERROR   = 4'd8
  } boot_state_e;

  // Image header: word count N, high byte first.
  localparam int HDR_LEN_HI_POS = 0;
  localparam int HDR_LEN_LO_POS = 1;
  localparam int HDR_BYTES      = 2;

  function automatic logic is_loading(boot_state_e s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: is_loading = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHK_HI, ST_CHK_LO:                         is_loading = 1'b1;
`endif
      default:                                      is_loading = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/boot_byte_timer.sv
// boot_byte_timer: inter-byte watchdog for the boot loader.
//   clk, rst_n   : clock, async active-low reset
//   load_i       : restart the count at TIMEOUT (a byte arrived / load started)
//   clear_i      : park the counter at zero (loader idle); wins over load_i
//   expired_o    : counter has run down to zero
// The counter is zero when idle, so expired_o is only meaningful while the
// loader is in a loading state; the caller qualifies it.
module boot_byte_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)             cnt_d = '0;
    else if (load_i)         cnt_d = TW'(TIMEOUT);
    else if (cnt_q != '0)    cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Reaches zero TIMEOUT cycles after the cycle that loaded it.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: selects boot ROM or instruction RAM for the Hack CPU and
// loads a program image from UART bytes into the RAM.
//   clk, rst_n    : clock, async active-low reset
//   load_req      : pulse, start/restart a load (any state)
//   rx_valid/data : received UART byte strobe and value
//   pc            : CPU program counter
//   rom_instr     : boot ROM word at pc
//   ram_rdata     : RAM read data at ram_addr
//   ram_addr/wdata/we : RAM port; pc in RUN, write pointer otherwise
//   instruction   : to CPU, RAM in RUN, ROM otherwise
//   cpu_reset     : CPU held in reset while loading or in ERROR
//   loading/error : status
// Image: N (16-bit, big-endian) then N words hi/lo. N > 2**RAM_AW is rejected.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN appends a 16-bit trailer that
// must equal the mod-2^16 sum of the data words.
module boot_loader_ctrl
  import hack_boot_pkg::*;
#(
  parameter int RAM_AW  = 12,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [15:0]       pc,
  input  logic [15:0]       rom_instr,
  input  logic [15:0]       ram_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic [15:0]       instruction,
  output logic              cpu_reset,
  output logic              loading,
  output logic              error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_e ST_AFTER_DATA = ST_CHK_HI;
`else
  localparam boot_state_e ST_AFTER_DATA = ST_RUN;
`endif

  boot_state_e       state_q, state_d;
  logic [RAM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_AW:0]   count_q, count_d;    // words committed so far
  logic [RAM_AW:0]   len_q, len_d;        // N, already range-checked
  logic [7:0]        hi_q, hi_d;
  logic              ram_we_q, ram_we_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              cpu_reset_q, loading_q, error_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic [15:0] rx_word;
  logic        active, tmr_expired, last_commit;

  assign rx_word = {hi_q, rx_data};
  assign active  = is_loading(state_q);

  // The pointer advances on the cycle the RAM sees the write, so ram_addr
  // still points at the word being written. The final word's commit cycle is
  // therefore where the load completes.
  assign last_commit = ram_we_q && ((count_q + (RAM_AW+1)'(1)) == len_q);

  boot_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_req | (active & rx_valid)),
    .clear_i   (~is_loading(state_d)),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    len_d       = len_q;
    hi_d        = hi_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (ram_we_q) begin
      wr_ptr_d = wr_ptr_q + RAM_AW'(1);
      count_d  = count_q + (RAM_AW+1)'(1);
    end

    if (load_req) begin
      state_d  = ST_LEN_HI;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_LEN_HI: if (rx_valid) begin
          hi_d    = rx_data;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: if (rx_valid) begin
          len_d = rx_word[RAM_AW:0];
          if (rx_word == 16'd0)                     state_d = ST_AFTER_DATA;
          else if (int'(rx_word) > (1 << RAM_AW))   state_d = ST_ERROR;
          else                                      state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          if (last_commit) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            // Trailer may start on the commit cycle itself.
            if (rx_valid) begin
              hi_d    = rx_data;
              state_d = ST_CHK_LO;
            end else begin
              state_d = ST_CHK_HI;
            end
`else
            state_d = ST_RUN;
`endif
          end else if (rx_valid) begin
            hi_d    = rx_data;
            state_d = ST_DATA_LO;
          end
        end
        ST_DATA_LO: if (rx_valid) begin
          ram_we_d    = 1'b1;
          ram_wdata_d = rx_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_d       = sum_q + rx_word;
`endif
          state_d     = ST_DATA_HI;
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CHK_HI: if (rx_valid) begin
          hi_d    = rx_data;
          state_d = ST_CHK_LO;
        end
        ST_CHK_LO: if (rx_valid) begin
          state_d = (rx_word == sum_q) ? ST_RUN : ST_ERROR;
        end
`endif
        default: ;
      endcase

      // A byte arriving on the expiry cycle still counts.
      if (active && !rx_valid && tmr_expired) state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ROM;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b0;
      loading_q   <= 1'b0;
      error_q     <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      // Status decoded from the next state so it lines up with state_q.
      cpu_reset_q <= is_loading(state_d) | (state_d == ST_ERROR);
      loading_q   <= is_loading(state_d);
      error_q     <= (state_d == ST_ERROR);
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[15:RAM_AW];

  assign ram_addr    = (state_q == ST_RUN) ? pc[RAM_AW-1:0] : wr_ptr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign instruction = (state_q == ST_RUN) ? ram_rdata : rom_instr;
  assign cpu_reset   = cpu_reset_q;
  assign loading     = loading_q;
  assign error       = error_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl with a small RAM (16 words) and a
// short inter-byte timeout. Stimulus pushes expected RAM writes and expected
// load outcomes; a monitor pops them when the DUT writes or leaves loading.
module tb_boot_loader_ctrl;
  import hack_boot_pkg::*;

  localparam int AW    = 4;
  localparam int TO    = 40;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [15:0]   pc = 16'h0;
  logic [15:0]   rom_instr = 16'h0;
  logic [15:0]   ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_we;
  logic [15:0]   instruction;
  logic          cpu_reset, loading, error;

  always #5 clk = ~clk;

  boot_loader_ctrl #(.RAM_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .rx_valid(rx_valid),
    .rx_data(rx_data), .pc(pc), .rom_instr(rom_instr), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .instruction(instruction), .cpu_reset(cpu_reset), .loading(loading),
    .error(error)
  );

  // External instruction RAM.
  logic [15:0] ram [DEPTH];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  typedef struct { logic [AW-1:0] a; logic [15:0] d; } wr_t;
  wr_t         wq[$];        // expected RAM writes, in order
  bit          outq[$];      // expected load outcome: 1 = ERROR, 0 = RUN
  logic [15:0] exp_mem [DEPTH];
  logic [15:0] img[$];       // fixed words for the next image, else random
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pc        = 16'($urandom);
    rom_instr = 16'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic expect_write(input int a, input logic [15:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    wq.push_back(e);
    exp_mem[a] = d;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Image body after load_req: header, words, optional trailer.
  task automatic send_body(input int n, input bit bad_sum, input int stall);
    logic [15:0] n16, w, sum;
    logic [7:0]  hdr [HDR_BYTES];
    bit          exp_err;
    n16 = 16'(n);
    hdr[HDR_LEN_HI_POS] = n16[15:8];
    hdr[HDR_LEN_LO_POS] = n16[7:0];
    exp_err = (n > DEPTH);
`ifdef BOOT_LOADER_CHECKSUM_EN
    exp_err = exp_err || bad_sum;
`endif
    outq.push_back(exp_err);
    for (int i = 0; i < HDR_BYTES; i++) send_byte(hdr[i]);
    repeat (stall) tick();
    if (n <= DEPTH) begin
      sum = 16'h0;
      for (int i = 0; i < n; i++) begin
        w = (img.size() > i) ? img[i] : 16'($urandom);
        expect_write(i, w);
        sum = sum + w;
        send_word(w);
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      send_word(bad_sum ? sum + 16'd1 : sum);
`endif
    end
    img.delete();
  endtask

  task automatic wait_done();
    int k = 0;
    while ((outq.size() != 0 || wq.size() != 0) && k < 500) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 500) begin
      errors++;
      $display("FAIL wait_done pending_out=%0d pending_wr=%0d", outq.size(), wq.size());
    end
  endtask

  task automatic monitor();
    bit          prev_ld = 1'b0, in_run = 1'b0, e;
    wr_t         w;
    logic [15:0] exp_i;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ld = 1'b0;
        in_run  = 1'b0;
      end else begin
        if (loading && !prev_ld) in_run = 1'b0;
        if (ram_we) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h", ram_addr, ram_wdata);
          end else begin
            w = wq.pop_front();
            chk("write_addr", 32'(ram_addr), 32'(w.a));
            chk("write_data", 32'(ram_wdata), 32'(w.d));
          end
        end
        if (prev_ld && !loading) begin
          if (outq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load_end error=%0b", error);
          end else begin
            e = outq.pop_front();
            chk("end_error", 32'(error), 32'(e));
            chk("end_cpu_reset", 32'(cpu_reset), 32'(e));
            in_run = !e;
          end
        end
        exp_i = in_run ? exp_mem[pc[AW-1:0]] : rom_instr;
        chk("instruction", 32'(instruction), 32'(exp_i));
        prev_ld = loading;
      end
    end
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 16'h0;
      exp_mem[i] = 16'h0;
    end
    fork monitor(); join_none

    // Reset state
    rom_instr = 16'h1234;
    pc        = 16'd5;
    #12;
    chk("rst_instruction", 32'(instruction), 32'h1234);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1;
    tick();

    // Bytes in ROM belong to the CPU's echo program.
    repeat (4) send_byte(8'($urandom));

    // Two-word image
    img = '{16'hABCD, 16'h1234};
    pulse_load();
    send_body(2, 1'b0, 0);
    wait_done();
    repeat (8) tick();

    // Zero length, oversize length, exact-capacity length
    pulse_load();
    send_body(0, 1'b0, 0);
    wait_done();
    repeat (4) tick();
    pulse_load();
    send_body(DEPTH + 1, 1'b0, 0);
    wait_done();
    repeat (3) send_byte(8'($urandom));
    chk("err_sticky_error", 32'(error), 32'd1);
    chk("err_sticky_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("err_sticky_loading", 32'(loading), 32'd0);
    pulse_load();
    send_body(DEPTH, 1'b0, 0);
    wait_done();
    repeat (6) tick();

    // Stall after a word -> timeout, then recover
    pulse_load();
    outq.push_back(1'b1);
    send_word(16'h0002);
    w = 16'($urandom);
    expect_write(0, w);
    send_word(w);
    repeat (TO + 5) tick();
    wait_done();
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_load();
    send_body(2, 1'b0, 0);
    wait_done();

    // Gap just under the timeout must not abort
    pulse_load();
    send_body(1, 1'b0, TO - 5);
    wait_done();

    // load_req collides with the low byte of a word: byte dropped
    pulse_load();
    send_word(16'h0003);
    w = 16'($urandom);
    expect_write(0, w);
    send_word(w);
    w = 16'($urandom);
    send_byte(w[15:8]);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = w[7:0];
    tick();
    load_req = 1'b0;
    rx_valid = 1'b0;
    chk("collide_loading", 32'(loading), 32'd1);
    chk("collide_error", 32'(error), 32'd0);
    send_body(1, 1'b0, 0);
    wait_done();

    // Reset in the middle of a load
    pulse_load();
    send_word(16'h0003);
    w = 16'($urandom);
    expect_write(0, w);
    send_word(w);
    send_byte(8'($urandom));
    rst_n = 1'b0;
    #1;
    chk("midrst_loading", 32'(loading), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_pending_wr", 32'(wq.size()), 32'd0);
    repeat (4) tick();

`ifdef BOOT_LOADER_CHECKSUM_EN
    img = '{16'h0005};
    pulse_load();
    send_body(1, 1'b0, 0);
    wait_done();
    img = '{16'h0005};
    pulse_load();
    send_body(1, 1'b1, 0);
    wait_done();
`endif

    // Random images
    for (int r = 0; r < 10; r++) begin
      pulse_load();
      send_body($urandom_range(0, DEPTH + 2), ($urandom_range(0, 3) == 0), 0);
      wait_done();
      repeat ($urandom_range(2, 6)) tick();
    end

    chk("final_wq_empty", 32'(wq.size()), 32'd0);
    chk("final_outq_empty", 32'(outq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
